// File: rtl/color_calc_pkg.sv
// color_calc_pkg: shared state type and constants for the colour frame sequencer.
// Used by color_calc_sched and color_sched_out_reg.
package color_calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    CALC,
    EMIT,
    DONE
  } sched_state_t;

  localparam int RGB_W = 24;
  localparam int CALC_LAT_DEF = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/color_sched_out_reg.sv
// color_sched_out_reg: valid/ready hold register for the LED beat.
// Data and index stay frozen while valid is high and ready is low.
module color_sched_out_reg
  import color_calc_pkg::*;
#(
  parameter int AW = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RGB_W-1:0] load_rgb,
  input  logic [AW-1:0]    load_idx,
  input  logic             led_ready,
  output logic             led_valid,
  output logic [RGB_W-1:0] led_rgb,
  output logic [AW-1:0]    led_idx
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_valid <= 1'b0;
      led_rgb   <= '0;
      led_idx   <= '0;
    end else if (load) begin
      led_valid <= 1'b1;
      led_rgb   <= load_rgb;
      led_idx   <= load_idx;
    end else if (led_valid && led_ready) begin
      led_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/color_calc_sched.sv
// color_calc_sched: walks the note table, feeds the colour stage, streams RGB beats.
// Build option COLOR_SCHED_SKIP_ZERO_EN bypasses the colour wait for zero fast amplitude.
module color_calc_sched
  import color_calc_pkg::*;
#(
  parameter int W         = 6,
  parameter int D         = 10,
  parameter int NUM_NOTES = 12,
  parameter int CALC_LAT  = CALC_LAT_DEF,
  localparam int AW       = idx_w(NUM_NOTES)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             note_rd_en,
  output logic [AW-1:0]    note_rd_addr,
  input  logic [W+D-1:0]   note_amp_rd,
  input  logic [W+D-1:0]   note_ampf_rd,
  input  logic [D-1:0]     note_hue_rd,
  output logic [W+D-1:0]   calc_amp,
  output logic [W+D-1:0]   calc_ampf,
  output logic [D-1:0]     calc_hue,
  input  logic [RGB_W-1:0] calc_rgb,
  output logic             led_valid,
  input  logic             led_ready,
  output logic [RGB_W-1:0] led_rgb,
  output logic [AW-1:0]    led_idx
);

  localparam int CW = idx_w(CALC_LAT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NOTES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CALC_LAT - 1);

  sched_state_t     state;
  logic [AW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             skip;
  logic             ld;
  logic [RGB_W-1:0] ld_rgb;
  logic             hs;

`ifdef COLOR_SCHED_SKIP_ZERO_EN
  assign skip = (note_ampf_rd == '0);
`else
  assign skip = 1'b0;
`endif

  assign hs = led_valid & led_ready;

  // Beat load: settled colour at the end of CALC, or black on a skipped entry
  always_comb begin
    ld     = 1'b0;
    ld_rgb = calc_rgb;
    unique case (1'b1)
      (state == CAP) && skip: begin
        ld     = 1'b1;
        ld_rgb = '0;
      end
      (state == CALC) && (cnt == LAST_CNT): ld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      note_rd_en   <= 1'b0;
      note_rd_addr <= '0;
      calc_amp     <= '0;
      calc_ampf    <= '0;
      calc_hue     <= '0;
    end else begin
      note_rd_en <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= RD;
            idx          <= '0;
            busy         <= 1'b1;
            note_rd_en   <= 1'b1;
            note_rd_addr <= '0;
          end
        end
        RD: state <= CAP;
        CAP: begin
          calc_amp  <= note_amp_rd;
          calc_ampf <= note_ampf_rd;
          calc_hue  <= note_hue_rd;
          cnt       <= '0;
          state     <= skip ? EMIT : CALC;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx          <= idx + 1'b1;
              state        <= RD;
              note_rd_en   <= 1'b1;
              note_rd_addr <= idx + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  color_sched_out_reg #(
    .AW(AW)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_rgb (ld_rgb),
    .load_idx (idx),
    .led_ready(led_ready),
    .led_valid(led_valid),
    .led_rgb  (led_rgb),
    .led_idx  (led_idx)
  );

endmodule

// File: tb/tb_color_calc_sched.sv
// tb_color_calc_sched: self-checking bench with a note-table and colour-stage model.
// Expected beats and frame timing come from a per-entry cost model.
module tb_color_calc_sched;

  localparam int N   = 12;
  localparam int LAT = 3;
`ifdef COLOR_SCHED_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [15:0] amp;
    logic [15:0] ampf;
    logic [9:0]  hue;
    logic [23:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, frame_done, note_rd_en;
  logic [3:0]  note_rd_addr;
  logic [15:0] note_amp_rd, note_ampf_rd;
  logic [9:0]  note_hue_rd;
  logic [15:0] calc_amp, calc_ampf;
  logic [9:0]  calc_hue;
  logic [23:0] calc_rgb;
  logic        led_valid, led_ready;
  logic [23:0] led_rgb;
  logic [3:0]  led_idx;

  logic        ready_man, rnd_mode, rnd_bit;
  assign led_ready = rnd_mode ? rnd_bit : ready_man;

  always #5 clk = ~clk;

  color_calc_sched #(
    .W(6), .D(10), .NUM_NOTES(N), .CALC_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .frame_done(frame_done), .note_rd_en(note_rd_en),
    .note_rd_addr(note_rd_addr), .note_amp_rd(note_amp_rd),
    .note_ampf_rd(note_ampf_rd), .note_hue_rd(note_hue_rd),
    .calc_amp(calc_amp), .calc_ampf(calc_ampf), .calc_hue(calc_hue),
    .calc_rgb(calc_rgb), .led_valid(led_valid), .led_ready(led_ready),
    .led_rgb(led_rgb), .led_idx(led_idx)
  );

  // Stand-in colour stage: one hue sector lights one channel
  function automatic logic [23:0] colour_fn(input logic [15:0] a,
                                            input logic [15:0] af,
                                            input logic [9:0] h);
    logic [7:0] v;
    int sel;
    logic [23:0] c;
    if (af == 16'd0) return 24'h0;
    v = (af >= 16'd512) ? 8'hFF : af[8:1];
    sel = (int'(h) * 3) >> 10;
    c = (sel == 0) ? {v, 16'h0} : (sel == 1) ? {8'h0, v, 8'h0} : {16'h0, v};
    return c ^ {16'h0, a[7:0]};
  endfunction

  logic [15:0] t_amp[16], t_ampf[16];
  logic [9:0]  t_hue[16];
  logic [23:0] exp_rgb[N];
  logic [23:0] p1, p2;

  always @(posedge clk) begin
    if (note_rd_en) begin
      note_amp_rd  <= t_amp[note_rd_addr];
      note_ampf_rd <= t_ampf[note_rd_addr];
      note_hue_rd  <= t_hue[note_rd_addr];
    end
    p1 <= colour_fn(calc_amp, calc_ampf, calc_hue);
    p2 <= p1;
  end
  assign calc_rgb = p2;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          beats_idx[$];
  logic [23:0] beats_rgb[$];
  int          done_cnt = 0, done_cyc = 0, stall_cnt = 0;
  int          busy_low = 0, hold_viol = 0;
  logic        trk = 1'b0;
  logic        pv = 1'b0, phs = 1'b0;
  logic [23:0] prgb = '0;
  logic [3:0]  pidx = '0;

  always @(negedge clk) begin
    if (!rst) begin
      pv <= 1'b0;
    end else begin
      if (led_valid && led_ready) begin
        beats_idx.push_back(int'(led_idx));
        beats_rgb.push_back(led_rgb);
      end
      if (led_valid && !led_ready) stall_cnt <= stall_cnt + 1;
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (trk && !busy && !frame_done) busy_low <= busy_low + 1;
      if (pv && !phs && (!led_valid || led_rgb !== prgb || led_idx !== pidx))
        hold_viol <= hold_viol + 1;
      pv   <= led_valid;
      phs  <= led_valid && led_ready;
      prgb <= led_rgb;
      pidx <= led_idx;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input string tag, input bit extra_start, input bit bp3);
    int c_s, b0, d0, s0, bl0, sum;
    bit ok;
    logic [23:0] h_rgb;
    logic [3:0]  h_idx;
    int bad_hold, bad_rd;
    b0 = beats_idx.size();
    d0 = done_cnt;
    s0 = stall_cnt;
    bl0 = busy_low;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c_s = cyc;
    trk = 1'b1;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    if (extra_start) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (bp3) begin
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        if (note_rd_en && note_rd_addr == 4'd3) begin ok = 1; break; end
        @(negedge clk);
      end
      chk({tag, "_rd3_seen"}, 32'(ok), 32'd1);
      ready_man = 1'b0;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (led_valid) begin ok = 1; break; end
      end
      chk({tag, "_emit3_seen"}, 32'(ok), 32'd1);
      h_rgb = led_rgb;
      h_idx = led_idx;
      bad_hold = 0;
      bad_rd = 0;
      for (int k = 0; k < 20; k++) begin
        if (k > 0) @(negedge clk);
        if (!led_valid || led_rgb !== h_rgb || led_idx !== h_idx) bad_hold++;
        if (note_rd_en) bad_rd++;
      end
      ready_man = 1'b1;
      chk({tag, "_stall_idx"}, 32'(h_idx), 32'd3);
      chk({tag, "_stall_hold"}, 32'(bad_hold), 32'd0);
      chk({tag, "_stall_no_read"}, 32'(bad_rd), 32'd0);
    end
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1; break; end
    end
    trk = 1'b0;
    chk({tag, "_done_timeout"}, 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    sum = 0;
    for (int i = 0; i < N; i++)
      sum += (SKIP && t_ampf[i] == 16'd0) ? 3 : 3 + LAT;
    chk({tag, "_beats"}, 32'(beats_idx.size() - b0), 32'(N));
    for (int i = 0; i < N; i++) begin
      if (b0 + i < beats_idx.size()) begin
        chk($sformatf("%s_idx%0d", tag, i), 32'(beats_idx[b0 + i]), 32'(i));
        chk($sformatf("%s_rgb%0d", tag, i), 32'(beats_rgb[b0 + i]), 32'(exp_rgb[i]));
      end
    end
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_latency"}, 32'(done_cyc - c_s), 32'(sum + stall_cnt - s0));
    chk({tag, "_busy_held"}, 32'(busy_low - bl0), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[N];

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      t_amp[i]   = vt[i].amp;
      t_ampf[i]  = vt[i].ampf;
      t_hue[i]   = vt[i].hue;
      exp_rgb[i] = vt[i].rgb;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      t_amp[i]   = 16'($urandom);
      t_ampf[i]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      t_hue[i]   = 10'($urandom_range(0, 1023));
      exp_rgb[i] = colour_fn(t_amp[i], t_ampf[i], t_hue[i]);
    end
  endtask

  initial begin
    bit ok;
    vt[0]  = '{16'h0400, 16'd640,  10'd0,   24'hFF0000};
    vt[1]  = '{16'h0400, 16'd100,  10'd85,  24'h320000};
    vt[2]  = '{16'h0405, 16'd700,  10'd170, 24'hFF0005};
    vt[3]  = '{16'h0400, 16'd0,    10'd255, 24'h000000};
    vt[4]  = '{16'h0400, 16'd511,  10'd340, 24'hFF0000};
    vt[5]  = '{16'h0400, 16'd512,  10'd425, 24'h00FF00};
    vt[6]  = '{16'h04AA, 16'd2,    10'd510, 24'h0001AA};
    vt[7]  = '{16'h0400, 16'd1,    10'd595, 24'h000000};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 10'd680, 24'h00FFFF};
    vt[9]  = '{16'h0400, 16'd300,  10'd765, 24'h000096};
    vt[10] = '{16'h0433, 16'd0,    10'd850, 24'h000000};
    vt[11] = '{16'h0400, 16'd1023, 10'd935, 24'h0000FF};
    for (int i = 0; i < 16; i++) begin
      t_amp[i] = '0;
      t_ampf[i] = '0;
      t_hue[i] = '0;
    end
    rst = 1'b0;
    start = 1'b0;
    ready_man = 1'b1;
    rnd_mode = 1'b0;
    load_table();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_rd_en", 32'(note_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(note_rd_addr), 32'd0);
    chk("rst_calc_amp", 32'(calc_amp), 32'd0);
    chk("rst_calc_ampf", 32'(calc_ampf), 32'd0);
    chk("rst_calc_hue", 32'(calc_hue), 32'd0);
    chk("rst_valid", 32'(led_valid), 32'd0);
    chk("rst_rgb", 32'(led_rgb), 32'd0);
    chk("rst_idx", 32'(led_idx), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("tbl", 1'b0, 1'b0);
    run_frame("bp", 1'b0, 1'b1);
    load_random();
    rnd_mode = 1'b1;
    run_frame("rnd_start5", 1'b1, 1'b0);
    load_random();
    run_frame("rnd", 1'b0, 1'b0);
    rnd_mode = 1'b0;

    load_table();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (note_rd_en && note_rd_addr == 4'd2) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("mid_rst_rd2_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctl", 32'({busy, frame_done, note_rd_en, led_valid}), 32'd0);
    chk("mid_rst_addr_idx", 32'({note_rd_addr, led_idx}), 32'd0);
    chk("mid_rst_calc_amp", 32'(calc_amp), 32'd0);
    chk("mid_rst_calc_ampf", 32'(calc_ampf), 32'd0);
    chk("mid_rst_calc_hue", 32'(calc_hue), 32'd0);
    chk("mid_rst_rgb", 32'(led_rgb), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("after_rst", 1'b0, 1'b0);

    chk("hold_until_handshake", 32'(hold_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
